// File: rtl/tick_sequencer.sv
// Run/pause/step tick controller for the up/down counter and 7-segment display path.
// Conditions the async buttons, divides the clock into ticks and issues one-cycle enables.
module tick_sequencer #(
  parameter int unsigned TICK_DIV = 150000000,
  parameter int unsigned CNT_W    = 28
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic start_i,
  input  logic stop_i,
  input  logic step_i,
  input  logic down_in_i,
  output logic ena_o,
  output logic down_o,
  output logic running_o,
  output logic blank_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_STEP  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  // bit0/bit1 form the synchroniser, bit2 is the edge-detect history flop
  logic [2:0]       start_sync_q, stop_sync_q, step_sync_q;
  logic [1:0]       down_sync_q;
  logic             start_rise, stop_rise, step_rise, div_wrap;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             ena_q, ena_d, down_q, down_d, running_q, blank_q;

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      start_sync_q <= '0;
      stop_sync_q  <= '0;
      step_sync_q  <= '0;
      down_sync_q  <= '0;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_i};
      stop_sync_q  <= {stop_sync_q[1:0], stop_i};
      step_sync_q  <= {step_sync_q[1:0], step_i};
      down_sync_q  <= {down_sync_q[0], down_in_i};
    end
  end

  assign start_rise = start_sync_q[1] & ~start_sync_q[2];
  assign stop_rise  = stop_sync_q[1]  & ~stop_sync_q[2];
  assign step_rise  = step_sync_q[1]  & ~step_sync_q[2];
  assign div_wrap   = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (start_rise) state_d = S_RUN;
      end
      S_RUN: begin
        // a stop landing on the wrap cycle still lets that tick out
        if (stop_rise) begin
          state_d = S_PAUSE;
          if (div_wrap) div_d = '0;
        end else begin
          div_d = div_wrap ? '0 : div_q + CNT_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop_rise) begin
          state_d = S_IDLE;
          div_d   = '0;
        end else if (start_rise) begin
          state_d = S_RUN;
        end else if (step_rise) begin
          state_d = S_STEP;
          div_d   = '0;
        end
      end
      default: begin
        state_d = S_PAUSE;
        div_d   = '0;
      end
    endcase
    ena_d  = ((state_q == S_RUN) && div_wrap) || (state_d == S_STEP);
    down_d = ena_q ? down_q : down_sync_q[1];
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      ena_q     <= 1'b0;
      down_q    <= 1'b0;
      running_q <= 1'b0;
      blank_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      ena_q     <= ena_d;
      down_q    <= down_d;
      running_q <= (state_d == S_RUN);
      blank_q   <= (state_d == S_IDLE);
    end
  end

  assign ena_o     = ena_q;
  assign down_o    = down_q;
  assign running_o = running_q;
  assign blank_o   = blank_q;

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: a per-cycle vector table, hand-built corner sequences and
// random stimulus, all checked against a behavioural tick/mode model.
module tb_tick_sequencer;
  localparam int TD = 4;
  localparam int CW = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, step = 1'b0, down_in = 1'b0;
  logic ena, down, running, blank;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;

  tick_sequencer #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .start_i(start), .stop_i(stop), .step_i(step),
    .down_in_i(down_in), .ena_o(ena), .down_o(down), .running_o(running), .blank_o(blank)
  );

  // model: input history (index k = value sampled k edges ago), mode and clocks since last tick
  logic [3:1] h_start, h_stop, h_step, h_down;
  int   m_mode, m_el;
  logic m_ena, m_down;

  typedef struct packed {logic st, sp, stp, dn, ena, run, blank, down;} vec_t;
  vec_t tbl [20];

  task automatic check(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    h_start = '0; h_stop = '0; h_step = '0; h_down = '0;
    m_mode = M_IDLE; m_el = 0; m_ena = 1'b0; m_down = 1'b0;
  endtask

  task automatic model_step();
    logic sr, pr, tr;
    sr = h_start[2] & ~h_start[3];
    pr = h_stop[2]  & ~h_stop[3];
    tr = h_step[2]  & ~h_step[3];
    if (!m_ena) m_down = h_down[2];
    h_start = {h_start[2:1], start};
    h_stop  = {h_stop[2:1], stop};
    h_step  = {h_step[2:1], step};
    h_down  = {h_down[2:1], down_in};
    m_ena = 1'b0;
    case (m_mode)
      M_IDLE: if (sr) begin m_mode = M_RUN; m_el = 0; end
      M_RUN: begin
        if (pr) begin
          if (m_el + 1 == TD) begin m_ena = 1'b1; m_el = 0; end
          m_mode = M_PAUSE;
        end else begin
          m_el++;
          if (m_el == TD) begin m_ena = 1'b1; m_el = 0; end
        end
      end
      M_PAUSE: begin
        if (pr) begin m_mode = M_IDLE; m_el = 0; end
        else if (sr) m_mode = M_RUN;
        else if (tr) begin m_mode = M_STEP; m_el = 0; m_ena = 1'b1; end
      end
      default: m_mode = M_PAUSE;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check("mdl_ena", ena, m_ena);
    check("mdl_running", running, m_mode == M_RUN);
    check("mdl_blank", blank, m_mode == M_IDLE);
    check("mdl_down", down, m_down);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 1'b0; stop = 1'b0; step = 1'b0; down_in = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ena", ena, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_blank", blank, 1'b1);
    check("rst_down", down, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_running();
    int n = 0;
    while (!running && n < 12) begin cycle(); n++; end
    check("wait_running", running, 1'b1);
  endtask

  task automatic cycles_to_ena(string name, int exp);
    int n = 0;
    do begin cycle(); n++; end while (!ena && n < 3 * TD);
    check_int(name, n, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, first;
    tbl[0]  = 8'b1000_0010; tbl[1]  = 8'b1000_0010; tbl[2]  = 8'b1000_0100;
    tbl[3]  = 8'b1000_0100; tbl[4]  = 8'b0000_0100; tbl[5]  = 8'b0001_0100;
    tbl[6]  = 8'b0001_1100; tbl[7]  = 8'b0001_0100; tbl[8]  = 8'b0101_0101;
    tbl[9]  = 8'b0101_0101; tbl[10] = 8'b0001_1001; tbl[11] = 8'b0001_0001;
    tbl[12] = 8'b0011_0001; tbl[13] = 8'b0011_0001; tbl[14] = 8'b0011_1001;
    tbl[15] = 8'b0001_0001; tbl[16] = 8'b0100_0001; tbl[17] = 8'b0100_0001;
    tbl[18] = 8'b0000_0010; tbl[19] = 8'b1000_0010;

    model_reset();
    repeat (3) @(posedge clk);
    do_reset();

    // vector table: start, tick, stop on wrap cycle, held step, stop to IDLE, down hold
    for (int i = 0; i < 20; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; step = tbl[i].stp; down_in = tbl[i].dn;
      cycle();
      check($sformatf("tbl%0d_ena", i), ena, tbl[i].ena);
      check($sformatf("tbl%0d_running", i), running, tbl[i].run);
      check($sformatf("tbl%0d_blank", i), blank, tbl[i].blank);
      check($sformatf("tbl%0d_down", i), down, tbl[i].down);
    end

    // 10 ticks in 40 clocks, first one 4 clocks after running rises
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    wait_running();
    cnt = 0; first = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (ena) begin cnt++; if (first == 0) first = i; end
    end
    check_int("run_first_tick", first, TD);
    check_int("run_tick_count", cnt, 10);

    // pause with divider frozen at 2, stay silent, resume ticks after 2 clocks
    do_reset();
    start = 1'b1; cycle(); start = 1'b0; cycle(); cycle();
    stop = 1'b1; cycle(); stop = 1'b0; cycle(); cycle();
    check("pause_running", running, 1'b0);
    check("pause_blank", blank, 1'b0);
    cnt = 0;
    repeat (20) begin cycle(); if (ena) cnt++; end
    check_int("pause_silent", cnt, 0);
    start = 1'b1; cycle(); start = 1'b0;
    wait_running();
    cycles_to_ena("resume_latency", 2);

    // three held step pulses while paused, then divider must restart from 0
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (3) cycle();
    cnt = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1'b1; repeat (5) begin cycle(); if (ena) cnt++; end
      step = 1'b0; repeat (4) begin cycle(); if (ena) cnt++; end
    end
    check_int("step_ticks", cnt, 3);
    check("step_back_pause", running | blank, 1'b0);
    start = 1'b1; cycle(); start = 1'b0;
    wait_running();
    cycles_to_ena("after_step_latency", TD);

    // async reset mid-RUN with divider at 3, then silence without a new start
    do_reset();
    start = 1'b1; cycle(); start = 1'b0;
    wait_running();
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_ena", ena, 1'b0);
    check("async_running", running, 1'b0);
    check("async_blank", blank, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    cnt = 0;
    repeat (12) begin cycle(); if (ena) cnt++; end
    check_int("post_reset_silent", cnt, 0);

    // random buttons and direction switch against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) start = ~start;
      if ($urandom_range(0, 7) == 0) stop = ~stop;
      if ($urandom_range(0, 5) == 0) step = ~step;
      if ($urandom_range(0, 3) == 0) down_in = ~down_in;
      if (i == 200) do_reset();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
